painterengine_gpu_dma_writer: RTL and testbench

- Write-side DMA stage of the GPU pipeline.
- Consumes a 32-bit word stream from one of four routed sources; each source uses a valid/next handshake, the same as the DMA reader's output.
- Writes the stream to memory as 128-byte-aligned INCR bursts over AXI full write channels (AW/W/B).
- Runs one job per reset: a controller programs address/length/router, waits for done or error, then pulses resetn to start the next job.

---
 rtl/painterengine_gpu_dma_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_painterengine_gpu_dma_writer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/painterengine_gpu_dma_writer.sv
// Write-side DMA stage: streams 32-bit words from one routed source into memory
// as 128-byte-aligned AXI INCR bursts, one job per reset.
module painterengine_gpu_dma_writer #(
    parameter int TIMEOUT_BIT = 18
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    output logic         o_wire_done,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    input  logic [3:0]   i_wire_router,
    input  logic [127:0] i_wire_data,
    input  logic [3:0]   i_wire_data_valid,
    output logic [3:0]   o_wire_data_next,
    output logic         o_wire_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_M_AXI_AWID,
    output logic [31:0]  o_wire_M_AXI_AWADDR,
    output logic [7:0]   o_wire_M_AXI_AWLEN,
    output logic [2:0]   o_wire_M_AXI_AWSIZE,
    output logic [1:0]   o_wire_M_AXI_AWBURST,
    output logic         o_wire_M_AXI_AWLOCK,
    output logic [3:0]   o_wire_M_AXI_AWCACHE,
    output logic [2:0]   o_wire_M_AXI_AWPROT,
    output logic [3:0]   o_wire_M_AXI_AWQOS,
    output logic         o_wire_M_AXI_AWVALID,
    input  logic         i_wire_M_AXI_AWREADY,
    output logic [31:0]  o_wire_M_AXI_WDATA,
    output logic [3:0]   o_wire_M_AXI_WSTRB,
    output logic         o_wire_M_AXI_WLAST,
    output logic         o_wire_M_AXI_WVALID,
    input  logic         i_wire_M_AXI_WREADY,
    input  logic         i_wire_M_AXI_BID,
    input  logic [1:0]   i_wire_M_AXI_BRESP,
    input  logic         i_wire_M_AXI_BVALID,
    output logic         o_wire_M_AXI_BREADY
);

    typedef enum logic [2:0] {
        ROUTING     = 3'd0,
        PARAM_CHECK = 3'd1,
        CALC        = 3'd2,
        AW          = 3'd3,
        W           = 3'd4,
        B           = 3'd5,
        DONE        = 3'd6,
        ERROR       = 3'd7
    } state_t;

    state_t               state, state_next;
    logic [2:0]           error_type, error_type_next;
    logic [31:0]          address, length, offset;
    logic [1:0]           idx;
    logic [7:0]           beat;
    logic [TIMEOUT_BIT:0] stall;
    logic [5:0]           burst_len;

    logic                 route_ok;
    logic [1:0]           route_idx;
    logic [31:0]          remaining, offset_sum;
    logic [4:0]           align_pos;
    logic [5:0]           aligned, burst_calc;
    logic                 aw_hs, w_hs, b_hs, last_beat, timed_out;
    logic                 unused_bid;

    assign unused_bid = i_wire_M_AXI_BID;

    always_comb begin
        route_ok  = 1'b1;
        route_idx = 2'd0;
        case (i_wire_router)
            4'b0001: route_idx = 2'd0;
            4'b0010: route_idx = 2'd1;
            4'b0100: route_idx = 2'd2;
            4'b1000: route_idx = 2'd3;
            default: route_ok  = 1'b0;
        endcase
    end

    // Bursts stop at the next 32-word (128-byte) boundary or at the end of the job.
    assign remaining  = length - offset;
    assign align_pos  = address[6:2] + offset[4:0];
    assign aligned    = 6'd32 - {1'b0, align_pos};
    assign burst_calc = (remaining < {26'd0, aligned}) ? remaining[5:0] : aligned;
    assign offset_sum = offset + {26'd0, burst_len};
    assign last_beat  = (beat == ({2'b00, burst_len} - 8'd1));

    assign aw_hs     = (state == AW) && i_wire_M_AXI_AWREADY;
    assign w_hs      = (state == W) && i_wire_data_valid[idx] && i_wire_M_AXI_WREADY;
    assign b_hs      = (state == B) && i_wire_M_AXI_BVALID;
    assign timed_out = stall[TIMEOUT_BIT];

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state      <= ROUTING;
            error_type <= 3'd0;
        end else begin
            state      <= state_next;
            error_type <= error_type_next;
        end
    end

    always_comb begin
        state_next      = state;
        error_type_next = error_type;
        case (state)
            ROUTING: begin
                if (route_ok) begin
                    state_next = PARAM_CHECK;
                end else begin
                    state_next      = ERROR;
                    error_type_next = 3'd1;
                end
            end
            PARAM_CHECK: begin
                if ((address[1:0] != 2'b00) || (length == 32'd0)) begin
                    state_next      = ERROR;
                    error_type_next = 3'd2;
                end else begin
                    state_next = CALC;
                end
            end
            CALC: state_next = AW;
            AW: begin
                if (timed_out) begin
                    state_next      = ERROR;
                    error_type_next = 3'd3;
                end else if (aw_hs) begin
                    state_next = W;
                end
            end
            W: begin
                if (timed_out) begin
                    state_next      = ERROR;
                    error_type_next = 3'd4;
                end else if (w_hs && last_beat) begin
                    state_next = B;
                end
            end
            B: begin
                if (timed_out) begin
                    state_next      = ERROR;
                    error_type_next = 3'd6;
                end else if (b_hs) begin
                    if (i_wire_M_AXI_BRESP != 2'b00) begin
                        state_next      = ERROR;
                        error_type_next = 3'd5;
                    end else if (offset_sum >= length) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            DONE:  error_type_next = 3'd0;
            ERROR: state_next = ERROR;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            address   <= 32'd0;
            length    <= 32'd0;
            offset    <= 32'd0;
            idx       <= 2'd0;
            beat      <= 8'd0;
            stall     <= '0;
            burst_len <= 6'd0;
        end else begin
            if (aw_hs || w_hs || b_hs || !(state inside {AW, W, B})) begin
                stall <= '0;
            end else begin
                stall <= stall + 1'b1;
            end
            case (state)
                ROUTING: begin
                    if (route_ok) begin
                        idx     <= route_idx;
                        address <= i_wire_address[{route_idx, 5'd0} +: 32];
                        length  <= i_wire_length[{route_idx, 5'd0} +: 32];
                    end
                end
                PARAM_CHECK: offset <= 32'd0;
                CALC:        burst_len <= burst_calc;
                AW:          if (aw_hs) beat <= 8'd0;
                W:           if (w_hs) beat <= beat + 8'd1;
                B: begin
                    if (b_hs && (i_wire_M_AXI_BRESP == 2'b00)) begin
                        offset <= offset_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    // The source handshake is passed straight through; nothing is buffered here.
    always_comb begin
        o_wire_data_next = 4'b0000;
        if (state == W) begin
            o_wire_data_next[idx] = i_wire_M_AXI_WREADY;
        end
    end

    assign o_wire_done          = (state == DONE);
    assign o_wire_error         = (state == ERROR);
    assign o_wire_error_type    = error_type;

    assign o_wire_M_AXI_AWID    = 1'b0;
    assign o_wire_M_AXI_AWADDR  = address + {offset[29:0], 2'b00};
    assign o_wire_M_AXI_AWLEN   = {2'b00, burst_len} - 8'd1;
    assign o_wire_M_AXI_AWSIZE  = 3'b010;
    assign o_wire_M_AXI_AWBURST = 2'b01;
    assign o_wire_M_AXI_AWLOCK  = 1'b0;
    assign o_wire_M_AXI_AWCACHE = 4'b0010;
    assign o_wire_M_AXI_AWPROT  = 3'b000;
    assign o_wire_M_AXI_AWQOS   = 4'b0000;
    assign o_wire_M_AXI_AWVALID = (state == AW);

    assign o_wire_M_AXI_WDATA   = i_wire_data[{idx, 5'd0} +: 32];
    assign o_wire_M_AXI_WSTRB   = 4'hF;
    assign o_wire_M_AXI_WLAST   = (state == W) && last_beat;
    assign o_wire_M_AXI_WVALID  = (state == W) && i_wire_data_valid[idx];

    assign o_wire_M_AXI_BREADY  = (state == B);

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Bench for painterengine_gpu_dma_writer: table vectors, randomized jobs against a
// burst-splitting reference model, and hand sequences for timeouts and mid-burst reset.
module tb_painterengine_gpu_dma_writer;

    localparam int TIMEOUT_BIT    = 8;
    localparam int TIMEOUT_CYCLES = 1 << TIMEOUT_BIT;

    logic         clock = 1'b0;
    logic         resetn;
    logic         done;
    logic [127:0] address_in;
    logic [127:0] length_in;
    logic [3:0]   router;
    logic [127:0] data_in;
    logic [3:0]   data_valid;
    logic [3:0]   data_next;
    logic         error;
    logic [2:0]   error_type;
    logic         awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic [3:0]   awqos;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic         bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    always #5 clock = ~clock;

    painterengine_gpu_dma_writer #(.TIMEOUT_BIT(TIMEOUT_BIT)) dut (
        .i_wire_clock(clock),
        .i_wire_resetn(resetn),
        .o_wire_done(done),
        .i_wire_address(address_in),
        .i_wire_length(length_in),
        .i_wire_router(router),
        .i_wire_data(data_in),
        .i_wire_data_valid(data_valid),
        .o_wire_data_next(data_next),
        .o_wire_error(error),
        .o_wire_error_type(error_type),
        .o_wire_M_AXI_AWID(awid),
        .o_wire_M_AXI_AWADDR(awaddr),
        .o_wire_M_AXI_AWLEN(awlen),
        .o_wire_M_AXI_AWSIZE(awsize),
        .o_wire_M_AXI_AWBURST(awburst),
        .o_wire_M_AXI_AWLOCK(awlock),
        .o_wire_M_AXI_AWCACHE(awcache),
        .o_wire_M_AXI_AWPROT(awprot),
        .o_wire_M_AXI_AWQOS(awqos),
        .o_wire_M_AXI_AWVALID(awvalid),
        .i_wire_M_AXI_AWREADY(awready),
        .o_wire_M_AXI_WDATA(wdata),
        .o_wire_M_AXI_WSTRB(wstrb),
        .o_wire_M_AXI_WLAST(wlast),
        .o_wire_M_AXI_WVALID(wvalid),
        .i_wire_M_AXI_WREADY(wready),
        .i_wire_M_AXI_BID(bid),
        .i_wire_M_AXI_BRESP(bresp),
        .i_wire_M_AXI_BVALID(bvalid),
        .o_wire_M_AXI_BREADY(bready)
    );

    typedef struct {
        logic [3:0]  router;
        logic [31:0] addr;
        logic [31:0] len;
        logic [2:0]  exp_type;
        int          exp_bursts;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Per-job bench state: source stream, observed AXI traffic, slave behaviour knobs
    logic [31:0] src_words[$];
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int          burst_beats_q[$];
    logic [31:0] model_addr[$];
    int          model_len[$];
    int          src_ptr, sel, wbeats, cur_beat, b_pending, viol, aw_valid_cycles, gap_left;
    logic [3:0]  sel_mask;
    bit          b_hs_flag;
    int          aw_mode, w_mode, src_mode, b_mode;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference burst split: each burst runs to the next 128-byte boundary or the end of the job
    function automatic void buildModel(input logic [31:0] base, input int unsigned len);
        int unsigned sent;
        int unsigned room;
        int unsigned n;
        logic [31:0] a;
        model_addr.delete();
        model_len.delete();
        sent = 0;
        while (sent < len) begin
            a    = base + 32'(sent * 4);
            room = 32 - (int'(a % 32'd128) / 4);
            n    = ((len - sent) < room) ? (len - sent) : room;
            model_addr.push_back(a);
            model_len.push_back(int'(n));
            sent += n;
        end
    endfunction

    function automatic logic [2:0] expectedType(input logic [3:0] r, input logic [31:0] a, input logic [31:0] l);
        if ($countones(r) != 1) return 3'd1;
        if ((a % 32'd4) != 32'd0 || l == 32'd0) return 3'd2;
        return 3'd0;
    endfunction

    task automatic applyStimulus();
        logic v;
        if (b_hs_flag) begin
            bvalid    = 1'b0;
            b_hs_flag = 1'b0;
        end
        case (aw_mode)
            1:       awready = 1'b1;
            2:       awready = 1'b0;
            default: awready = 1'($urandom_range(0, 1));
        endcase
        case (w_mode)
            1:       wready = 1'b1;
            2:       wready = ~wready;
            default: wready = 1'($urandom_range(0, 1));
        endcase
        if (src_ptr >= src_words.size()) begin
            v = 1'b0;
        end else begin
            case (src_mode)
                0: v = ($urandom_range(0, 9) < 7);
                1: v = 1'b1;
                2: begin
                    if (src_ptr == 3 && gap_left > 0) begin
                        v = 1'b0;
                        gap_left--;
                    end else begin
                        v = 1'b1;
                    end
                end
                default: v = 1'b0;
            endcase
        end
        for (int ch = 0; ch < 4; ch++) begin
            data_in[ch*32 +: 32] = $urandom;
            data_valid[ch]       = 1'($urandom_range(0, 1));
        end
        if (src_ptr < src_words.size()) data_in[sel*32 +: 32] = src_words[src_ptr];
        data_valid[sel] = v;
        if (!bvalid && b_pending > 0 && b_mode != 1 && $urandom_range(0, 2) != 0) begin
            bvalid = 1'b1;
            bresp  = (b_mode == 2) ? 2'b10 : 2'b00;
        end
        bid = 1'($urandom_range(0, 1));
    endtask

    // Looks at the settled outputs and records every handshake the next rising edge will complete
    task automatic observeCycle();
        bit src_hs, w_hs;
        src_hs = (sel_mask != 4'b0) && data_valid[sel] && data_next[sel];
        w_hs   = wvalid && wready;
        if (awvalid) aw_valid_cycles++;
        if (awvalid && awready) begin
            aw_addr_q.push_back(awaddr);
            aw_len_q.push_back(awlen);
        end
        if (src_hs != w_hs) viol++;
        if (w_hs) begin
            if (aw_addr_q.size() <= burst_beats_q.size()) viol++;
            if (src_ptr >= src_words.size()) viol++;
            else if (wdata !== src_words[src_ptr]) viol++;
            wbeats++;
            cur_beat++;
            if (wlast) begin
                burst_beats_q.push_back(cur_beat);
                cur_beat = 0;
                b_pending++;
            end
        end
        if (src_hs) src_ptr++;
        if ((data_next & ~sel_mask) != 4'b0) viol++;
        if (wvalid && data_next != (wready ? sel_mask : 4'b0)) viol++;
        if (bvalid && bready) begin
            b_pending--;
            b_hs_flag = 1'b1;
        end
    endtask

    task automatic runJob(input logic [3:0] r, input logic [31:0] addr, input logic [31:0] len,
                          input int max_cycles, input int stop_beats, output int cycles);
        @(negedge clock);
        resetn = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            address_in[ch*32 +: 32] = $urandom;
            length_in[ch*32 +: 32]  = $urandom;
        end
        sel_mask = r;
        case (r)
            4'b0001: sel = 0;
            4'b0010: sel = 1;
            4'b0100: sel = 2;
            4'b1000: sel = 3;
            default: begin
                sel      = 0;
                sel_mask = 4'b0;
            end
        endcase
        address_in[sel*32 +: 32] = addr;
        length_in[sel*32 +: 32]  = len;
        router = r;
        src_words.delete();
        aw_addr_q.delete();
        aw_len_q.delete();
        burst_beats_q.delete();
        for (int i = 0; i < int'(len) && i < 512; i++) src_words.push_back($urandom);
        src_ptr = 0; wbeats = 0; cur_beat = 0; b_pending = 0; viol = 0; aw_valid_cycles = 0;
        gap_left = 5; b_hs_flag = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; data_valid = 4'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        cycles = 0;
        while (cycles < max_cycles) begin
            @(negedge clock);
            if (cycles == 2) begin
                address_in = {$urandom, $urandom, $urandom, $urandom};
                length_in  = {$urandom, $urandom, $urandom, $urandom};
                router     = 4'($urandom_range(0, 15));
            end
            applyStimulus();
            #1;
            observeCycle();
            cycles++;
            if (done || error) break;
            if (stop_beats > 0 && wbeats >= stop_beats) break;
        end
    endtask

    task automatic checkJob(input string name, input logic [31:0] addr, input logic [31:0] len,
                            input logic [2:0] exp_type);
        int mism;
        bit ok;
        ok = (exp_type == 3'd0);
        checkOutput({name, "_done"}, 64'(done), 64'(ok));
        checkOutput({name, "_error"}, 64'(error), 64'(!ok));
        checkOutput({name, "_type"}, 64'(error_type), 64'(exp_type));
        checkOutput({name, "_protocol"}, 64'(viol), 64'd0);
        if (ok) begin
            buildModel(addr, int'(len));
            checkOutput({name, "_burst_count"}, 64'(aw_addr_q.size()), 64'(model_addr.size()));
            mism = 0;
            for (int i = 0; i < model_addr.size(); i++) begin
                if (i >= aw_addr_q.size()) mism++;
                else if (aw_addr_q[i] !== model_addr[i] || aw_len_q[i] !== 8'(model_len[i] - 1)) mism++;
                if (i >= burst_beats_q.size()) mism++;
                else if (burst_beats_q[i] != model_len[i]) mism++;
            end
            checkOutput({name, "_bursts"}, 64'(mism), 64'd0);
            checkOutput({name, "_beats"}, 64'(wbeats), 64'(len));
        end else begin
            checkOutput({name, "_no_data"}, 64'(wbeats), 64'd0);
        end
    endtask

    initial begin
        vec_t        vecs[9];
        int          cyc;
        logic [3:0]  r;
        logic [31:0] a, l;

        resetn = 1'b0; router = 4'b0; address_in = '0; length_in = '0; data_in = '0;
        data_valid = 4'b0; awready = 1'b0; wready = 1'b0; bid = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        aw_mode = 1; w_mode = 1; src_mode = 1; b_mode = 0; sel = 0; sel_mask = 4'b0;
        #1;
        checkOutput("reset_outputs",
                    64'({done, error, error_type, awvalid, wvalid, wlast, bready, data_next}), 64'd0);
        checkOutput("axi_constants",
                    64'({awid, awsize, awburst, awlock, awcache, awprot, awqos, wstrb}),
                    64'({1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000, 4'hF}));

        vecs[0] = '{4'b0010, 32'h1000_0000, 32'd8,  3'd0, 1};
        vecs[1] = '{4'b0010, 32'h1000_0078, 32'd40, 3'd0, 3};
        vecs[2] = '{4'b0011, 32'h1000_0000, 32'd8,  3'd1, 0};
        vecs[3] = '{4'b0001, 32'h1000_0002, 32'd8,  3'd2, 0};
        vecs[4] = '{4'b1000, 32'h2000_0004, 32'd33, 3'd0, 2};
        vecs[5] = '{4'b0100, 32'h0000_007C, 32'd1,  3'd0, 1};
        vecs[6] = '{4'b0000, 32'h0000_0000, 32'd4,  3'd1, 0};
        vecs[7] = '{4'b0001, 32'h3000_0000, 32'd0,  3'd2, 0};
        vecs[8] = '{4'b0100, 32'h0000_0000, 32'd64, 3'd0, 2};

        for (int i = 0; i < 9; i++) begin
            aw_mode  = (i < 2) ? 1 : 0;
            w_mode   = (i < 2) ? 1 : 0;
            src_mode = (i < 2) ? 1 : 0;
            b_mode   = 0;
            runJob(vecs[i].router, vecs[i].addr, vecs[i].len, 3000, 0, cyc);
            checkJob($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].exp_type);
            checkOutput($sformatf("vec%0d_table_bursts", i), 64'(aw_addr_q.size()), 64'(vecs[i].exp_bursts));
            if (vecs[i].exp_type != 3'd0)
                checkOutput($sformatf("vec%0d_no_awvalid", i), 64'(aw_valid_cycles), 64'd0);
        end

        for (int j = 0; j < 20; j++) begin
            r = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
            l = ($urandom_range(0, 14) == 0) ? 32'd0 : 32'($urandom_range(1, 100));
            aw_mode = 0; w_mode = $urandom_range(0, 1) * 2; src_mode = 0; b_mode = 0;
            runJob(r, a, l, 4000, 0, cyc);
            checkJob($sformatf("rand%0d", j), a, l, expectedType(r, a, l));
        end

        aw_mode = 1; w_mode = 2; src_mode = 2; b_mode = 0;
        runJob(4'b0010, 32'h1000_0010, 32'd20, 2000, 0, cyc);
        checkJob("gap", 32'h1000_0010, 32'd20, 3'd0);

        aw_mode = 2; w_mode = 1; src_mode = 1; b_mode = 0;
        runJob(4'b0001, 32'h1000_0000, 32'd8, TIMEOUT_CYCLES + 100, 0, cyc);
        checkJob("aw_timeout", 32'h1000_0000, 32'd8, 3'd3);
        checkOutput("aw_timeout_window", 64'(cyc >= TIMEOUT_CYCLES && cyc <= TIMEOUT_CYCLES + 8), 64'd1);

        aw_mode = 1; w_mode = 1; src_mode = 3; b_mode = 0;
        runJob(4'b0100, 32'h1000_0000, 32'd8, TIMEOUT_CYCLES + 100, 0, cyc);
        checkJob("w_timeout", 32'h1000_0000, 32'd8, 3'd4);

        aw_mode = 1; w_mode = 1; src_mode = 1; b_mode = 1;
        runJob(4'b1000, 32'h1000_0000, 32'd8, TIMEOUT_CYCLES + 100, 0, cyc);
        checkOutput("b_timeout_type", 64'(error_type), 64'd6);
        checkOutput("b_timeout_error", 64'(error), 64'd1);

        b_mode = 2;
        runJob(4'b0010, 32'h1000_0000, 32'd8, 2000, 0, cyc);
        checkOutput("bresp_type", 64'(error_type), 64'd5);
        checkOutput("bresp_error", 64'(error), 64'd1);
        checkOutput("bresp_done", 64'(done), 64'd0);

        // Pull reset while the third beat of a burst is on the bus
        aw_mode = 1; w_mode = 1; src_mode = 1; b_mode = 0;
        runJob(4'b0010, 32'h1000_0000, 32'd16, 2000, 2, cyc);
        @(posedge clock);
        #2;
        checkOutput("rst_beat3_active", 64'(wvalid), 64'd1);
        resetn = 1'b0;
        #1;
        checkOutput("rst_mid_burst_outputs",
                    64'({done, error, error_type, awvalid, wvalid, wlast, bready, data_next}), 64'd0);
        runJob(4'b0100, 32'h2000_0040, 32'd12, 2000, 0, cyc);
        checkJob("after_reset", 32'h2000_0040, 32'd12, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
